alu_ctrl_dmem: RTL and testbench
================================

ALU_CTRL_DMEM -- requirements
Module: alu_ctrl_dmem

Interface
REQ-001 SHALL expose ports: clk in 1, system clock; rising edge active.
REQ-002 SHALL expose ports: reset in 1, synchronous active-high reset.
REQ-003 SHALL expose ports: instruction in 8, current instruction; opcode [7:4], field rA [3:2], field rB [1:0].
REQ-004 SHALL expose ports: pc in 8, current PC; unused except as documented.
REQ-005 SHALL expose ports: decode_en in 1, execute_en in 1, access_mem in 1; single-cycle stage strobes.
REQ-006 SHALL expose ports: in0 in 8, in1 in 8, ALU operands.
REQ-007 SHALL expose ports: reg_addr_0, reg_addr_1, reg_addr_w out 2 each, source and destination register addresses.
REQ-008 SHALL expose ports: mem_w_en, mem_r_en, reg_w_en out 1 each; sel_w_source out 8, all-ones or zero mask.
REQ-009 SHALL expose ports: out out 8, ALU result; overflow out 1; jump out 8, all-ones or zero mask.
REQ-010 SHALL expose ports: data_address in 8, write_data in 8, read_data out 8, memory port.

Function
REQ-011 SHALL register all decode outputs on clk when decode_en=1, and hold them otherwise.
- Default decode: addr_0=rA, addr_1=rB, addr_w=rA; all enables 0; sel=00.
REQ-012 SHALL decode opcodes, with writes to rA via reg_w_en=1 for ALU ops:
- 0000 nop: no write.
- 0001 add; 0010 sub; 0011 and; 0100 or.
- 0101 slt: signed compare, result 1/0.
- 0110 addi: in0 + sign-extended rB field.
- 0111 sll: in0 << in1[2:0].
- 1110 srl: logical shift right by in1[2:0].
- 1111 nop: no write.
REQ-013 SHALL decode jumps and memory ops as follows:
- 1000 j: no enables.
- 1001 jal: mem_w_en=1 (stack push performed by caller).
- 1010 lw: addr_0=rB, addr_w=rA, mem_r_en=1, reg_w_en=1, sel_w_source=FF.
- 1011 sw: addr_0=rB, addr_1=rA, mem_w_en=1.
- 1100 beq and 1101 bne: no enables.
REQ-014 SHALL register out, overflow and jump on clk when execute_en=1, computed from current instruction/in0/in1.
REQ-015 SHALL, for j/jal, drive out = sign-extended instruction[3:0] and jump=FF.
REQ-016 SHALL, for beq (in0==in1) or bne (in0!=in1), drive jump=FF and out=01 when taken, and jump=00, out=00 when not taken.
REQ-017 SHALL drive jump=00 for all non-jump opcodes, and out=00 for nop and lw/sw.
REQ-018 SHALL compute all arithmetic modulo 256.
REQ-019 SHALL set overflow only on signed overflow of add, sub or addi, and clear it otherwise.
REQ-020 SHALL implement a 256x8 data memory.
- On clk with access_mem=1 and mem_w_en=1: mem[data_address] <= write_data.
- On clk with access_mem=1: read_data <= old mem[data_address] (read-before-write).
- access_mem=0: memory and read_data unchanged.
REQ-021 SHALL apply decode (when decode_en=1) and execute (when execute_en=1) on the same edge if both strobes coincide; execute uses the instruction input, never the decode registers.

Reset
REQ-022 SHALL, on clk with reset=1, clear all registered outputs to 0, taking priority over every strobe.
REQ-023 SHALL NOT alter memory contents on reset; memory contents SHALL initialise to 00 at power-up/simulation start.

Configuration
REQ-024 SHALL compile overflow detection only when ALU_CTRL_DMEM_OVERFLOW_EN is defined.
- Without ALU_CTRL_DMEM_OVERFLOW_EN: overflow SHALL be tied 0; all other behaviour identical.

Verification
REQ-025 SHALL cover: instruction=0x16 (add r1,r2), in0=0x7F, in1=0x01, decode_en then execute_en -> addr_w=1, reg_w_en=1, out=0x80, overflow=1 (0 with macro undefined).
REQ-026 SHALL cover: sw 0xB6 with data_address=0x10, write_data=0xAB, access_mem, then lw 0xA6 with access_mem -> mem_w_en=1 then mem_r_en=1, sel_w_source=FF, read_data=0xAB.
REQ-027 SHALL cover: beq 0xC1 with in0=in1=0x05 -> jump=FF, out=01; in1=0x06 -> jump=00, out=00.
REQ-028 SHALL cover: j 0x8E -> jump=FF, out=0xFE; jal 0x93 -> mem_w_en=1, out=0x03, jump=FF.
REQ-029 SHALL cover: reset asserted with decode_en and execute_en high -> all outputs 0 next edge; previously written memory still readable.
REQ-030 SHALL cover: strobes low, inputs changing -> all outputs hold.

Source files
------------

// File: rtl/alu_ctrl_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_ctrl_dmem                                                 |
// | Purpose  : Combined instruction decoder, 8-bit ALU/branch unit and       |
// |            256x8 data memory for a small 8-bit processor.                |
// |                                                                          |
// | Ports    : clk, reset          - clock, synchronous active-high reset    |
// |            instruction, pc     - current instruction (op[7:4], rA[3:2],  |
// |                                  rB[1:0]) and PC (not used here)         |
// |            decode_en           - capture decode outputs                  |
// |            execute_en          - capture out / overflow / jump           |
// |            access_mem          - perform the data-memory access          |
// |            in0, in1            - ALU operands                            |
// |            reg_addr_0/1/w      - source / destination register addresses |
// |            mem_w_en, mem_r_en, reg_w_en, sel_w_source - decode controls  |
// |            out, overflow, jump - ALU result, signed overflow, jump mask  |
// |            data_address, write_data, read_data - data-memory port        |
// |                                                                          |
// | Config   : ALU_CTRL_DMEM_OVERFLOW_EN - when defined, overflow reports    |
// |            signed overflow of add/sub/addi; otherwise tied to 0.         |
// |                                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_ctrl_dmem (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  input  logic [7:0] pc,
  input  logic       decode_en,
  input  logic       execute_en,
  input  logic       access_mem,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic [1:0] reg_addr_0,
  output logic [1:0] reg_addr_1,
  output logic [1:0] reg_addr_w,
  output logic       mem_w_en,
  output logic       mem_r_en,
  output logic       reg_w_en,
  output logic [7:0] sel_w_source,
  output logic [7:0] out,
  output logic       overflow,
  output logic [7:0] jump,
  input  logic [7:0] data_address,
  input  logic [7:0] write_data,
  output logic [7:0] read_data
);

  localparam logic [3:0] c_op_nop0 = 4'b0000;
  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_sub  = 4'b0010;
  localparam logic [3:0] c_op_and  = 4'b0011;
  localparam logic [3:0] c_op_or   = 4'b0100;
  localparam logic [3:0] c_op_slt  = 4'b0101;
  localparam logic [3:0] c_op_addi = 4'b0110;
  localparam logic [3:0] c_op_sll  = 4'b0111;
  localparam logic [3:0] c_op_j    = 4'b1000;
  localparam logic [3:0] c_op_jal  = 4'b1001;
  localparam logic [3:0] c_op_lw   = 4'b1010;
  localparam logic [3:0] c_op_sw   = 4'b1011;
  localparam logic [3:0] c_op_beq  = 4'b1100;
  localparam logic [3:0] c_op_bne  = 4'b1101;
  localparam logic [3:0] c_op_srl  = 4'b1110;
  localparam logic [3:0] c_op_nop1 = 4'b1111;

  logic [3:0] w_op;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic [7:0] w_imm2;   // rB field sign-extended (addi)
  logic [7:0] w_imm4;   // instruction[3:0] sign-extended (j/jal)
  logic [7:0] w_sum;
  logic [7:0] w_diff;
  logic [7:0] w_addi;

  assign w_op   = instruction[7:4];
  assign w_ra   = instruction[3:2];
  assign w_rb   = instruction[1:0];
  assign w_imm2 = {{6{w_rb[1]}}, w_rb};
  assign w_imm4 = {{4{instruction[3]}}, instruction[3:0]};
  assign w_sum  = in0 + in1;
  assign w_diff = in0 - in1;
  assign w_addi = in0 + w_imm2;

  // The PC is part of the stage interface but nothing here depends on it.
  logic unused_pc;
  assign unused_pc = ^pc;

  // ---------------------------------------------------------------- decode
  logic [1:0] addr0_d, addr1_d, addrw_d;
  logic [1:0] addr0_q, addr1_q, addrw_q;
  logic       mw_d, mr_d, rw_d;
  logic       mw_q, mr_q, rw_q;
  logic [7:0] sel_d, sel_q;

  always_comb begin
    addr0_d = w_ra;
    addr1_d = w_rb;
    addrw_d = w_ra;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    rw_d    = 1'b0;
    sel_d   = 8'h00;
    case (w_op)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_slt, c_op_addi, c_op_sll, c_op_srl: rw_d = 1'b1;
      // jal only flags the stack push; the caller performs it.
      c_op_jal: mw_d = 1'b1;
      c_op_lw: begin
        addr0_d = w_rb;
        mr_d    = 1'b1;
        rw_d    = 1'b1;
        sel_d   = 8'hFF;
      end
      c_op_sw: begin
        addr0_d = w_rb;
        addr1_d = w_ra;
        mw_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- execute
  logic [7:0] out_d, out_q;
  logic [7:0] jump_d, jump_q;

  always_comb begin
    out_d  = 8'h00;
    jump_d = 8'h00;
    case (w_op)
      c_op_add:  out_d = w_sum;
      c_op_sub:  out_d = w_diff;
      c_op_and:  out_d = in0 & in1;
      c_op_or:   out_d = in0 | in1;
      c_op_slt:  out_d = {7'b0, ($signed(in0) < $signed(in1))};
      c_op_addi: out_d = w_addi;
      c_op_sll:  out_d = in0 << in1[2:0];
      c_op_srl:  out_d = in0 >> in1[2:0];
      c_op_j, c_op_jal: begin
        out_d  = w_imm4;
        jump_d = 8'hFF;
      end
      c_op_beq: if (in0 == in1) begin
        out_d  = 8'h01;
        jump_d = 8'hFF;
      end
      c_op_bne: if (in0 != in1) begin
        out_d  = 8'h01;
        jump_d = 8'hFF;
      end
      c_op_nop0, c_op_nop1, c_op_lw, c_op_sw: ;
      default: ;
    endcase
  end

  // ------------------------------------------------------------ data memory
  logic [7:0] mem_q [256] = '{default: 8'h00};
  logic [7:0] rdata_q;

  // Writes use the registered mem_w_en from a previous decode; reset blocks
  // them so the memory image survives a reset.
  always_ff @(posedge clk) begin
    if (!reset && access_mem && mw_q) begin
      mem_q[data_address] <= write_data;
    end
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr0_q <= 2'b00;
      addr1_q <= 2'b00;
      addrw_q <= 2'b00;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
      rw_q    <= 1'b0;
      sel_q   <= 8'h00;
      out_q   <= 8'h00;
      jump_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      if (decode_en) begin
        addr0_q <= addr0_d;
        addr1_q <= addr1_d;
        addrw_q <= addrw_d;
        mw_q    <= mw_d;
        mr_q    <= mr_d;
        rw_q    <= rw_d;
        sel_q   <= sel_d;
      end
      if (execute_en) begin
        out_q  <= out_d;
        jump_q <= jump_d;
      end
      // Read-before-write: the old word is returned on a write access.
      if (access_mem) begin
        rdata_q <= mem_q[data_address];
      end
    end
  end

`ifdef ALU_CTRL_DMEM_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: operands of like sign producing a result of the other sign
  // (for sub, the subtrahend's sign is inverted).
  always_comb begin
    ovf_d = 1'b0;
    case (w_op)
      c_op_add:  ovf_d = (in0[7] == in1[7])    && (w_sum[7]  != in0[7]);
      c_op_sub:  ovf_d = (in0[7] != in1[7])    && (w_diff[7] != in0[7]);
      c_op_addi: ovf_d = (in0[7] == w_imm2[7]) && (w_addi[7] != in0[7]);
      default:   ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (execute_en) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign reg_addr_0   = addr0_q;
  assign reg_addr_1   = addr1_q;
  assign reg_addr_w   = addrw_q;
  assign mem_w_en     = mw_q;
  assign mem_r_en     = mr_q;
  assign reg_w_en     = rw_q;
  assign sel_w_source = sel_q;
  assign out          = out_q;
  assign jump         = jump_q;
  assign read_data    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_ctrl_dmem                                              |
// | Purpose  : Scoreboard bench for alu_ctrl_dmem: directed scenarios then   |
// |            random traffic against a behavioural model of the block.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_ctrl_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic [7:0] instruction = 8'h00, pc = 8'h00, in0 = 8'h00, in1 = 8'h00;
  logic       decode_en = 1'b0, execute_en = 1'b0, access_mem = 1'b0;
  logic [7:0] data_address = 8'h00, write_data = 8'h00;
  logic [1:0] reg_addr_0, reg_addr_1, reg_addr_w;
  logic       mem_w_en, mem_r_en, reg_w_en, overflow;
  logic [7:0] sel_w_source, out, jump, read_data;

  alu_ctrl_dmem dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc(pc),
    .decode_en(decode_en), .execute_en(execute_en), .access_mem(access_mem),
    .in0(in0), .in1(in1),
    .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1), .reg_addr_w(reg_addr_w),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .reg_w_en(reg_w_en),
    .sel_w_source(sel_w_source), .out(out), .overflow(overflow), .jump(jump),
    .data_address(data_address), .write_data(write_data), .read_data(read_data)
  );

  typedef struct {
    logic [1:0] a0, a1, aw;
    logic       mw, mr, rw, ovf;
    logic [7:0] sel, res, jmp, rd;
  } exp_t;

  exp_t       m;          // model's view of the outputs after the last edge
  exp_t       e;          // monitor's popped expectation
  exp_t       q[$];
  logic [7:0] mem_m [256];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx8(input logic [7:0] v);
    return v[7] ? int'(v) - 256 : int'(v);
  endfunction

  // Reference model: derives the next outputs from the instruction-set rules
  // using plain integer arithmetic.
  task automatic model_next();
    exp_t       n;
    logic [3:0] op;
    logic [1:0] ra, rb;
    int         a, b, sa, sb, r, imm, sh;
    bit         v;
    logic [7:0] jm;
    n  = m;
    op = instruction[7:4];
    ra = instruction[3:2];
    rb = instruction[1:0];
    a  = int'(in0);
    b  = int'(in1);
    sa = sx8(in0);
    sb = sx8(in1);
    sh = b % 8;
    r  = 0;
    v  = 1'b0;
    jm = 8'h00;
    if (reset) begin
      n = '{a0: 2'd0, a1: 2'd0, aw: 2'd0, mw: 1'b0, mr: 1'b0, rw: 1'b0,
            ovf: 1'b0, sel: 8'h00, res: 8'h00, jmp: 8'h00, rd: 8'h00};
    end else begin
      if (decode_en) begin
        n.a0 = ra; n.a1 = rb; n.aw = ra;
        n.mw = 1'b0; n.mr = 1'b0; n.rw = 1'b0; n.sel = 8'h00;
        if ((op >= 4'd1 && op <= 4'd7) || op == 4'd14) n.rw = 1'b1;
        if (op == 4'd9) n.mw = 1'b1;
        if (op == 4'd10) begin n.a0 = rb; n.mr = 1'b1; n.rw = 1'b1; n.sel = 8'hFF; end
        if (op == 4'd11) begin n.a0 = rb; n.a1 = ra; n.mw = 1'b1; end
      end
      if (execute_en) begin
        case (op)
          4'd1: begin r = sa + sb; v = (r > 127) || (r < -128); end
          4'd2: begin r = sa - sb; v = (r > 127) || (r < -128); end
          4'd3: r = a & b;
          4'd4: r = a | b;
          4'd5: r = (sa < sb) ? 1 : 0;
          4'd6: begin
            imm = (int'(rb) >= 2) ? int'(rb) - 4 : int'(rb);
            r = sa + imm;
            v = (r > 127) || (r < -128);
          end
          4'd7:  r = a * (1 << sh);
          4'd14: r = a / (1 << sh);
          4'd8, 4'd9: begin
            imm = int'(instruction[3:0]);
            if (imm >= 8) imm = imm - 16;
            r  = imm;
            jm = 8'hFF;
          end
          4'd12: if (a == b) begin r = 1; jm = 8'hFF; end
          4'd13: if (a != b) begin r = 1; jm = 8'hFF; end
          default: r = 0;
        endcase
        n.res = 8'(r);
        n.jmp = jm;
`ifdef ALU_CTRL_DMEM_OVERFLOW_EN
        n.ovf = v;
`else
        n.ovf = 1'b0;
`endif
      end
      if (access_mem) begin
        n.rd = mem_m[data_address];
        if (m.mw) mem_m[data_address] = write_data;
      end
    end
    m = n;
    q.push_back(n);
  endtask

  // Drive one cycle's inputs, record the expectation, and return just after
  // the edge that consumes them.
  task automatic step(input logic [7:0] ins, input logic [7:0] i0, input logic [7:0] i1,
                      input logic dec, input logic ex, input logic acc, input logic rs,
                      input logic [7:0] da, input logic [7:0] wd);
    @(negedge clk);
    instruction  = ins;
    in0          = i0;
    in1          = i1;
    decode_en    = dec;
    execute_en   = ex;
    access_mem   = acc;
    reset        = rs;
    data_address = da;
    write_data   = wd;
    pc           = 8'($urandom);
    model_next();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge that has a pending expectation is checked.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("reg_addr_0",   8'(reg_addr_0), 8'(e.a0));
      chk("reg_addr_1",   8'(reg_addr_1), 8'(e.a1));
      chk("reg_addr_w",   8'(reg_addr_w), 8'(e.aw));
      chk("mem_w_en",     8'(mem_w_en),   8'(e.mw));
      chk("mem_r_en",     8'(mem_r_en),   8'(e.mr));
      chk("reg_w_en",     8'(reg_w_en),   8'(e.rw));
      chk("sel_w_source", sel_w_source,   e.sel);
      chk("out",          out,            e.res);
      chk("overflow",     8'(overflow),   8'(e.ovf));
      chk("jump",         jump,           e.jmp);
      chk("read_data",    read_data,      e.rd);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    m = '{a0: 2'd0, a1: 2'd0, aw: 2'd0, mw: 1'b0, mr: 1'b0, rw: 1'b0,
          ovf: 1'b0, sel: 8'h00, res: 8'h00, jmp: 8'h00, rd: 8'h00};

    // Reset state
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("rst_out", out, 8'h00);
    chk("rst_jump", jump, 8'h00);

    // add r1,r2 with signed overflow
    step(8'h16, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(8'h16, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("add_addr_w", 8'(reg_addr_w), 8'h01);
    chk("add_reg_w_en", 8'(reg_w_en), 8'h01);
    chk("add_out", out, 8'h80);
`ifdef ALU_CTRL_DMEM_OVERFLOW_EN
    chk("add_ovf", 8'(overflow), 8'h01);
`else
    chk("add_ovf", 8'(overflow), 8'h00);
`endif

    // sw then lw through the data memory
    step(8'hB6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("sw_mem_w_en", 8'(mem_w_en), 8'h01);
    chk("sw_addr_0", 8'(reg_addr_0), 8'h02);
    step(8'hB6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'hAB);
    step(8'hA6, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    step(8'hA6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("lw_mem_r_en", 8'(mem_r_en), 8'h01);
    chk("lw_sel", sel_w_source, 8'hFF);
    chk("lw_read_data", read_data, 8'hAB);

    // beq taken / not taken
    step(8'hC1, 8'h05, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("beq_t_jump", jump, 8'hFF);
    chk("beq_t_out", out, 8'h01);
    step(8'hC1, 8'h05, 8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("beq_nt_jump", jump, 8'h00);
    chk("beq_nt_out", out, 8'h00);

    // j and jal
    step(8'h8E, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("j_out", out, 8'hFE);
    chk("j_jump", jump, 8'hFF);
    step(8'h93, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("jal_mem_w_en", 8'(mem_w_en), 8'h01);
    chk("jal_out", out, 8'h03);

    // Strobes low: everything holds while inputs wander
    for (int i = 0; i < 4; i++)
      step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0,
           8'($urandom), 8'($urandom));
    chk("hold_out", out, 8'h03);
    chk("hold_jump", jump, 8'hFF);
    chk("hold_read_data", read_data, 8'hAB);

    // Reset wins over strobes; memory survives
    step(8'h16, 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("rst2_out", out, 8'h00);
    chk("rst2_reg_w_en", 8'(reg_w_en), 8'h00);
    chk("rst2_read_data", read_data, 8'h00);
    step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    chk("mem_survives_rst", read_data, 8'hAB);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
           8'($urandom_range(0, 7)), 8'($urandom));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
